divisor_frequencia_programavel: RTL and testbench

Parametrised, runtime-programmable clock divider replacing the fixed divide-by-202 generator. It derives a divided square wave and a one-cycle tick from the board clock, and supports three modes: free-running toggle, tick-only, and single-step. Divisor reloads are glitch-free. It feeds the processor core clock and the slow peripheral enables.

---
 rtl/divisor_frequencia_programavel.sv | 264 ++++++++++++++++++++++++++
 tb/tb_divisor_frequencia_programavel.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_frequencia_programavel.sv
// -----------------------------------------------------------------------------
// divisor_frequencia_programavel
//
// Runtime-programmable clock divider. It produces a registered square wave
// (`clock`) and a registered one-cycle tick (`pulso`) from the board clock.
// Three operating modes are supported:
//   LIVRE  (00) : free-running, `clock` toggles every D+1 cycles.
//   PULSO  (01) : tick-only, `pulso` fires every D+1 cycles, `clock` held 0.
//   PASSO  (10) : single step, one `passo` strobe gives one high and one low
//                 half-period on `clock`, then a tick on `pulso`.
//   PARADO (11) : idle, nothing runs.
// A new divisor is staged in a pending register and only becomes active at a
// half-period boundary (or while idle), so the output never glitches.
//
// Parameters
//   LARGURA        : width of the counter and of the divisor.
//   DIVISOR_PADRAO : divisor loaded at reset.
//
// Ports
//   clockPlaca     in   board clock, everything on the rising edge
//   resetN         in   synchronous active-low reset
//   habilita       in   0 freezes counter, FSM and `clock`; `pulso` goes 0
//   modo           in   operating mode (see above)
//   passo          in   single-step request, only honoured while idle in PASSO
//   carregaDivisor in   load strobe for `divisorNovo`
//   divisorNovo    in   new divisor value
//   clock          out  divided clock
//   pulso          out  one-cycle tick
//   divisorAtual   out  divisor currently in use
//   pendente       out  a loaded divisor is waiting for a boundary
//   ocupado        out  a single-step sequence is in progress
// -----------------------------------------------------------------------------
module divisor_frequencia_programavel #(
   parameter int unsigned          LARGURA        = 16,
   parameter logic [LARGURA-1:0]   DIVISOR_PADRAO = LARGURA'(100)
) (
   input  logic               clockPlaca,
   input  logic               resetN,
   input  logic               habilita,
   input  logic [1:0]         modo,
   input  logic               passo,
   input  logic               carregaDivisor,
   input  logic [LARGURA-1:0] divisorNovo,
   output logic               clock,
   output logic               pulso,
   output logic [LARGURA-1:0] divisorAtual,
   output logic               pendente,
   output logic               ocupado
);

   // ---------------------------------------------------------------------
   // Types
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {
      LIVRE  = 2'b00,
      PULSO  = 2'b01,
      PASSO  = 2'b10,
      PARADO = 2'b11
   } modo_t;

   typedef enum logic [1:0] {
      OCIOSO      = 2'b00,
      CORRENDO    = 2'b01,
      PASSO_ALTO  = 2'b10,
      PASSO_BAIXO = 2'b11
   } estado_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   estado_t            estado_q,           estado_d;
   logic [LARGURA-1:0] contador_q,         contador_d;
   logic               clock_q,            clock_d;
   logic               pulso_q,            pulso_d;
   logic               ocupado_q,          ocupado_d;
   logic [LARGURA-1:0] divisor_atual_q,    divisor_atual_d;
   logic [LARGURA-1:0] divisor_pendente_q, divisor_pendente_d;
   logic               pendente_q,         pendente_d;
   logic [1:0]         modo_anterior_q,    modo_anterior_d;

   // ---------------------------------------------------------------------
   // Decoded conditions
   // ---------------------------------------------------------------------
   modo_t modo_atual;
   logic  troca_modo;
   logic  contando;
   logic  evento;
   logic  fronteira;

   assign modo_atual = modo_t'(modo);

   // Any mode change aborts whatever is running, regardless of habilita.
   assign troca_modo = (modo != modo_anterior_q);

   // The counter only advances outside OCIOSO.
   assign contando   = (estado_q != OCIOSO);

   // End of a half-period: the counter has reached the active divisor.
   assign evento     = habilita && contando && (contador_q == divisor_atual_q);

   // Points where the divisor may be swapped without shortening or
   // stretching a half-period: an evento, or any enabled idle edge.
   assign fronteira  = habilita && !troca_modo && (evento || (estado_q == OCIOSO));

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clockPlaca) begin
      // NOTE: reset is sampled on the clock edge, not in the sensitivity list;
      // every register here is a real control flop, so all of them are reset.
      if (!resetN) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // flop samples the values computed before this edge.
         estado_q           <= OCIOSO;
         contador_q         <= '0;
         clock_q            <= 1'b0;
         pulso_q            <= 1'b0;
         ocupado_q          <= 1'b0;
         divisor_atual_q    <= DIVISOR_PADRAO;
         divisor_pendente_q <= DIVISOR_PADRAO;
         pendente_q         <= 1'b0;
         // Track the live mode through reset so releasing reset is never
         // mistaken for a mode change.
         modo_anterior_q    <= modo;
      end else begin
         estado_q           <= estado_d;
         contador_q         <= contador_d;
         clock_q            <= clock_d;
         pulso_q            <= pulso_d;
         ocupado_q          <= ocupado_d;
         divisor_atual_q    <= divisor_atual_d;
         divisor_pendente_q <= divisor_pendente_d;
         pendente_q         <= pendente_d;
         modo_anterior_q    <= modo_anterior_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: default assignment first; without it the partial case branches
      // below would infer latches.
      estado_d = estado_q;

      if (troca_modo) begin
         estado_d = OCIOSO;
      end else if (habilita) begin
         case (estado_q)
            OCIOSO: begin
               if ((modo_atual == LIVRE) || (modo_atual == PULSO)) begin
                  estado_d = CORRENDO;
               end else if ((modo_atual == PASSO) && passo) begin
                  estado_d = PASSO_ALTO;
               end
            end
            CORRENDO: begin
               // Leaves only through a mode change.
               estado_d = CORRENDO;
            end
            PASSO_ALTO: begin
               if (evento) begin
                  estado_d = PASSO_BAIXO;
               end
            end
            PASSO_BAIXO: begin
               if (evento) begin
                  estado_d = OCIOSO;
               end
            end
            default: begin
               estado_d = OCIOSO;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output / datapath logic: counter, clock, tick, busy flag
   // ---------------------------------------------------------------------
   always_comb begin
      contador_d = contador_q;
      clock_d    = clock_q;
      pulso_d    = 1'b0;        // tick is only ever one cycle wide
      ocupado_d  = ocupado_q;

      if (troca_modo) begin
         contador_d = '0;
         clock_d    = 1'b0;
         ocupado_d  = 1'b0;
      end else if (habilita) begin
         if (contando) begin
            contador_d = evento ? '0 : (contador_q + LARGURA'(1));
         end else begin
            contador_d = '0;
         end

         case (estado_q)
            OCIOSO: begin
               if ((modo_atual == PASSO) && passo) begin
                  clock_d   = 1'b1;
                  ocupado_d = 1'b1;
               end
            end
            CORRENDO: begin
               if (modo_atual == PULSO) begin
                  clock_d = 1'b0;
               end else if (evento) begin
                  clock_d = ~clock_q;
               end
               pulso_d = evento;
            end
            PASSO_ALTO: begin
               if (evento) begin
                  clock_d = 1'b0;
               end
            end
            PASSO_BAIXO: begin
               if (evento) begin
                  pulso_d   = 1'b1;
                  ocupado_d = 1'b0;
               end
            end
            default: begin
               clock_d = 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Divisor staging
   // ---------------------------------------------------------------------
   always_comb begin
      divisor_atual_d    = divisor_atual_q;
      divisor_pendente_d = divisor_pendente_q;
      pendente_d         = pendente_q;
      modo_anterior_d    = modo;

      if (fronteira) begin
         // A load on the boundary edge itself bypasses the pending register.
         if (carregaDivisor) begin
            divisor_atual_d = divisorNovo;
         end else if (pendente_q) begin
            divisor_atual_d = divisor_pendente_q;
         end
         pendente_d = 1'b0;
      end else if (carregaDivisor) begin
         // Mid half-period: stage it; a later load simply overwrites.
         divisor_pendente_d = divisorNovo;
         pendente_d         = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign clock        = clock_q;
   assign pulso        = pulso_q;
   assign ocupado      = ocupado_q;
   assign divisorAtual = divisor_atual_q;
   assign pendente     = pendente_q;

endmodule

// File: tb/tb_divisor_frequencia_programavel.sv
// -----------------------------------------------------------------------------
// Testbench for divisor_frequencia_programavel.
// A behavioural model (countdown of edges left in the current half-period)
// is stepped on every rising edge and all outputs are compared each cycle;
// directed scenarios add explicit timing measurements, then a random phase
// exercises arbitrary combinations of the inputs.
// -----------------------------------------------------------------------------
module tb_divisor_frequencia_programavel;

   localparam int LARGURA = 16;

   logic               clockPlaca = 1'b0;
   logic               resetN;
   logic               habilita;
   logic [1:0]         modo;
   logic               passo;
   logic               carregaDivisor;
   logic [LARGURA-1:0] divisorNovo;
   logic               clock;
   logic               pulso;
   logic [LARGURA-1:0] divisorAtual;
   logic               pendente;
   logic               ocupado;

   int checks = 0;
   int erros  = 0;
   int cyc    = 0;

   divisor_frequencia_programavel #(
      .LARGURA        (LARGURA),
      .DIVISOR_PADRAO (16'd100)
   ) dut (
      .clockPlaca     (clockPlaca),
      .resetN         (resetN),
      .habilita       (habilita),
      .modo           (modo),
      .passo          (passo),
      .carregaDivisor (carregaDivisor),
      .divisorNovo    (divisorNovo),
      .clock          (clock),
      .pulso          (pulso),
      .divisorAtual   (divisorAtual),
      .pendente       (pendente),
      .ocupado        (ocupado)
   );

   always #5 clockPlaca = ~clockPlaca;

   // ---------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         erros++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   typedef enum int {F_PARADO, F_CORRE, F_ALTO, F_BAIXO} fase_t;

   fase_t       m_fase    = F_PARADO;
   bit          m_clock   = 1'b0;
   bit          m_pulso   = 1'b0;
   bit          m_ocupado = 1'b0;
   bit          m_pendente = 1'b0;
   int unsigned m_atual   = 100;
   int unsigned m_pend_val = 0;
   int unsigned m_faltam  = 0;   // counting edges left until the next evento
   logic [1:0]  m_modo_ant = 2'b00;

   task automatic modelo();
      bit ev;
      if (!resetN) begin
         m_fase = F_PARADO; m_clock = 0; m_pulso = 0; m_ocupado = 0;
         m_pendente = 0; m_atual = 100; m_faltam = 0; m_modo_ant = modo;
         return;
      end
      if (modo != m_modo_ant) begin
         m_modo_ant = modo;
         m_fase = F_PARADO; m_clock = 0; m_pulso = 0; m_ocupado = 0;
         if (carregaDivisor) begin m_pend_val = divisorNovo; m_pendente = 1; end
         return;
      end
      if (!habilita) begin
         m_pulso = 0;
         if (carregaDivisor) begin m_pend_val = divisorNovo; m_pendente = 1; end
         return;
      end
      ev = (m_fase != F_PARADO) && (m_faltam == 1);
      if (ev || m_fase == F_PARADO) begin
         if (carregaDivisor) m_atual = divisorNovo;
         else if (m_pendente) m_atual = m_pend_val;
         m_pendente = 0;
      end else if (carregaDivisor) begin
         m_pend_val = divisorNovo; m_pendente = 1;
      end
      m_pulso = 0;
      case (m_fase)
         F_PARADO: begin
            if (modo == 2'b00 || modo == 2'b01) begin
               m_fase = F_CORRE; m_faltam = m_atual + 1;
            end else if (modo == 2'b10 && passo) begin
               m_fase = F_ALTO; m_clock = 1; m_ocupado = 1; m_faltam = m_atual + 1;
            end
         end
         F_CORRE: begin
            if (ev) begin
               m_pulso = 1;
               if (modo == 2'b00) m_clock = !m_clock;
               m_faltam = m_atual + 1;
            end else m_faltam--;
         end
         F_ALTO: begin
            if (ev) begin m_clock = 0; m_fase = F_BAIXO; m_faltam = m_atual + 1; end
            else m_faltam--;
         end
         F_BAIXO: begin
            if (ev) begin m_pulso = 1; m_ocupado = 0; m_fase = F_PARADO; end
            else m_faltam--;
         end
         default: m_fase = F_PARADO;
      endcase
   endtask

   // One clock: step the model with the inputs seen at the edge, then compare.
   task automatic ciclo();
      int unsigned exp_cont;
      @(posedge clockPlaca);
      modelo();
      #1;
      cyc++;
      exp_cont = (m_fase != F_PARADO) ? (m_atual + 1 - m_faltam) : 0;
      check("clock",        clock,          m_clock);
      check("pulso",        pulso,          m_pulso);
      check("ocupado",      ocupado,        m_ocupado);
      check("pendente",     pendente,       m_pendente);
      check("divisorAtual", divisorAtual,   m_atual);
      check("contador",     dut.contador_q, exp_cont);
   endtask

   // Run until `clock` (qual=0) or `pulso` (qual=1) reads `valor`; n is the
   // number of cycles taken. An expired budget is a failed comparison.
   task automatic espera(input int qual, input logic valor, input int limite, output int n);
      logic s;
      n = 0;
      do begin
         ciclo();
         n++;
         s = (qual == 0) ? clock : pulso;
      end while (s !== valor && n < limite);
      if (s !== valor) check("timeout", s, valor);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int n, n2, t0, t1;
      int alto, ocup, pulsos;

      resetN = 0; habilita = 1; modo = 2'b00; passo = 0;
      carregaDivisor = 0; divisorNovo = '0;

      // Reset state
      ciclo(); ciclo();
      check("reset_div", divisorAtual, 100);
      check("reset_clock", clock, 0);

      // LIVRE, D=3 loaded on the first idle edge: first rise at edge 5
      resetN = 1; carregaDivisor = 1; divisorNovo = 16'd3;
      ciclo(); n = 1;
      carregaDivisor = 0;
      espera(0, 1'b1, 20, n2);
      check("primeira_subida", n + n2, 5);
      espera(0, 1'b0, 20, n);
      check("livre_alto", n, 4);
      espera(0, 1'b1, 20, n);
      check("livre_baixo", n, 4);

      // PULSO, D=2, with a 5-cycle habilita gap
      modo = 2'b01; carregaDivisor = 1; divisorNovo = 16'd2;
      ciclo();
      carregaDivisor = 0;
      espera(1, 1'b1, 20, n);
      espera(1, 1'b1, 20, n);
      check("pulso_periodo", n, 3);
      check("pulso_clock0", clock, 0);
      t0 = cyc;
      ciclo();
      habilita = 0;
      repeat (5) ciclo();
      habilita = 1;
      espera(1, 1'b1, 30, n);
      t1 = cyc;
      check("pulso_fase", t1 - t0, 8);

      // LIVRE, D=3, load 1 mid half-period
      modo = 2'b00; carregaDivisor = 1; divisorNovo = 16'd3;
      ciclo();
      carregaDivisor = 0;
      ciclo();
      espera(0, 1'b1, 20, n);
      ciclo();
      carregaDivisor = 1; divisorNovo = 16'd1;
      ciclo();
      carregaDivisor = 0;
      check("pendente_meio", pendente, 1);
      espera(0, 1'b0, 20, n);
      check("meio_alto_antigo", 2 + n, 4);
      check("pendente_limpo", pendente, 0);
      espera(0, 1'b1, 20, n);
      check("meio_baixo_novo", n, 2);
      check("meio_div", divisorAtual, 1);

      // Load on the evento edge, D=3 -> 5
      carregaDivisor = 1; divisorNovo = 16'd3;
      ciclo();
      carregaDivisor = 0;
      espera(0, !clock, 20, n);
      espera(0, !clock, 20, n);
      check("alinhado_d3", n, 4);
      repeat (3) ciclo();
      carregaDivisor = 1; divisorNovo = 16'd5;
      ciclo();
      carregaDivisor = 0;
      check("evento_pendente", pendente, 0);
      check("evento_div", divisorAtual, 5);
      espera(0, !clock, 20, n);
      check("evento_meio", n, 6);

      // PASSO, D=2, second passo while busy is ignored
      modo = 2'b10; carregaDivisor = 1; divisorNovo = 16'd2;
      ciclo();
      carregaDivisor = 0;
      ciclo();
      alto = 0; ocup = 0; pulsos = 0;
      for (int i = 0; i < 12; i++) begin
         passo = (i == 0 || i == 2);
         ciclo();
         alto   += int'(clock);
         ocup   += int'(ocupado);
         pulsos += int'(pulso);
      end
      passo = 0;
      check("passo_alto", alto, 3);
      check("passo_ocupado", ocup, 6);
      check("passo_pulsos", pulsos, 1);

      // Mode change while clock=1, then reset mid-step
      modo = 2'b00;
      ciclo();
      espera(0, 1'b1, 20, n);
      modo = 2'b10;
      ciclo();
      check("troca_clock", clock, 0);
      check("troca_contador", dut.contador_q, 0);
      passo = 1;
      ciclo();
      passo = 0;
      ciclo();
      resetN = 0;
      ciclo();
      check("rst_clock", clock, 0);
      check("rst_pulso", pulso, 0);
      check("rst_ocupado", ocupado, 0);
      check("rst_pendente", pendente, 0);
      check("rst_div", divisorAtual, 100);
      resetN = 1;

      // Random phase
      for (int i = 0; i < 2500; i++) begin
         resetN         = ($urandom_range(199) != 0);
         habilita       = ($urandom_range(7) != 0);
         if ($urandom_range(39) == 0) modo = 2'($urandom_range(3));
         passo          = ($urandom_range(3) == 0);
         carregaDivisor = ($urandom_range(9) == 0);
         divisorNovo    = LARGURA'($urandom_range(6));
         ciclo();
      end

      $display("CHECKS %0d ERRORS %0d", checks, erros);
      $finish;
   end

endmodule
